// File: rtl/rca_8bit.sv
// 8-bit ripple-carry adder with a one-cycle registered result stage.
// The carry chain is built from explicit full-adder stages; ovf compares carries into and out of bit 7.
module rca_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  input  logic       in_valid,
  output logic [7:0] S,
  output logic       Cout,
  output logic       ovf,
  output logic       out_valid
);

  logic [8:0] w_c;
  logic [7:0] w_s;
  logic [7:0] r_s;
  logic       r_cout;
  logic       r_ovf;
  logic       r_valid;

  assign w_c[0] = Cin;

  // One full-adder stage per bit; carries ripple from bit 0 upward.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_fa
      logic w_p;
      assign w_p       = A[gi] ^ B[gi];
      assign w_s[gi]   = w_p ^ w_c[gi];
      assign w_c[gi+1] = (A[gi] & B[gi]) | (w_c[gi] & w_p);
    end
  endgenerate

  // Result registers load only on accepted operations; out_valid pulses once per accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s     <= 8'h00;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_s    <= w_s;
        r_cout <= w_c[8];
        r_ovf  <= w_c[7] ^ w_c[8];
      end
    end
  end

  assign S         = r_s;
  assign Cout      = r_cout;
  assign ovf       = r_ovf;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_rca_8bit.sv
// Self-checking bench for rca_8bit: constant vector table, scoreboard queue,
// hand-written hold/reset sequences and a random sweep against A+B+Cin.
module tb_rca_8bit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic       Cin = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] S;
  logic       Cout;
  logic       ovf;
  logic       out_valid;

  rca_8bit dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .in_valid(in_valid),
    .S(S), .Cout(Cout), .ovf(ovf), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    res_t       exp;
  } vec_t;

  res_t exp_q[$];
  res_t last_exp;
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [8:0] sum;
    res_t r;
    sum    = {1'b0, a} + {1'b0, b} + {8'h00, cin};
    r.s    = sum[7:0];
    r.cout = sum[8];
    r.ovf  = (a[7] == b[7]) && (sum[7] != a[7]);
    return r;
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Drive on the falling edge; the expected result joins the scoreboard when issued.
  task automatic drive_exp(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           input logic v, input res_t e);
    @(negedge clk);
    A = a; B = b; Cin = cin; in_valid = v;
    if (v) begin
      exp_q.push_back(e);
      last_exp = e;
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic v);
    drive_exp(a, b, cin, v, model(a, b, cin));
  endtask

  // Monitor: out_valid must follow an accepted in_valid by exactly one edge.
  logic vld_at_edge;
  always @(posedge clk) begin
    vld_at_edge = in_valid && !rst;
    #1;
    check("out_valid", {9'd0, out_valid}, {9'd0, vld_at_edge});
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", 10'h3FF, 10'h000);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("result", {S, Cout, ovf}, e);
        $display("txn: S=%0d Cout=%0b ovf=%0b  expected S=%0d Cout=%0b ovf=%0b",
                 S, Cout, ovf, e.s, e.cout, e.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[10];

  initial begin
    tbl[0] = '{a: 8'd20,   b: 8'd31,   cin: 1'b1, exp: '{s: 8'd52,  cout: 1'b0, ovf: 1'b0}};
    tbl[1] = '{a: 8'hFF,   b: 8'h01,   cin: 1'b0, exp: '{s: 8'h00,  cout: 1'b1, ovf: 1'b0}};
    tbl[2] = '{a: 8'd127,  b: 8'd1,    cin: 1'b0, exp: '{s: 8'd128, cout: 1'b0, ovf: 1'b1}};
    tbl[3] = '{a: 8'h80,   b: 8'h80,   cin: 1'b0, exp: '{s: 8'h00,  cout: 1'b1, ovf: 1'b1}};
    tbl[4] = '{a: 8'd1,    b: 8'd1,    cin: 1'b0, exp: '{s: 8'd2,   cout: 1'b0, ovf: 1'b0}};
    tbl[5] = '{a: 8'd2,    b: 8'd2,    cin: 1'b0, exp: '{s: 8'd4,   cout: 1'b0, ovf: 1'b0}};
    tbl[6] = '{a: 8'd200,  b: 8'd100,  cin: 1'b0, exp: '{s: 8'd44,  cout: 1'b1, ovf: 1'b0}};
    tbl[7] = '{a: 8'hFF,   b: 8'hFF,   cin: 1'b1, exp: '{s: 8'hFF,  cout: 1'b1, ovf: 1'b0}};
    tbl[8] = '{a: 8'hFF,   b: 8'h00,   cin: 1'b1, exp: '{s: 8'h00,  cout: 1'b1, ovf: 1'b0}};
    tbl[9] = '{a: 8'h00,   b: 8'h00,   cin: 1'b1, exp: '{s: 8'h01,  cout: 1'b0, ovf: 1'b0}};

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("reset_state", {S, Cout, ovf}, 10'h000);
    check("reset_valid", {9'd0, out_valid}, 10'h000);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table applied back-to-back, one op per cycle.
    foreach (tbl[i]) drive_exp(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b1, tbl[i].exp);
    drive(8'd0, 8'd0, 1'b0, 1'b0);

    // Hold: outputs keep the last result while in_valid stays low.
    drive(8'd5, 8'd6, 1'b0, 1'b1);
    drive(8'hAA, 8'h55, 1'b1, 1'b0);
    repeat (3) begin
      @(posedge clk); #2;
      check("hold", {S, Cout, ovf}, last_exp);
    end

    // Reset between edges while out_valid is high; the op issued under reset is discarded.
    drive(8'd20, 8'd31, 1'b1, 1'b1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {S, Cout, ovf}, 10'h000);
    check("async_reset_valid", {9'd0, out_valid}, 10'h000);
    @(negedge clk);
    A = 8'd9; B = 8'd9; Cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("post_reset_hold", {S, Cout, ovf}, 10'h000);
    drive(8'd100, 8'd27, 1'b0, 1'b1);
    drive(8'd0, 8'd0, 1'b0, 1'b0);

    // Random sweep with random in_valid gaps.
    for (int k = 0; k < 400; k++) begin
      drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end
    drive(8'd0, 8'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 10'(exp_q.size()), 10'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rca_8bit.md
RCA_8BIT -- requirements
Module: rca_8bit

Interface
REQ-001 The block SHALL use these ports (name, direction, width, meaning), clock and reset first:
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 A  input  8  unsigned/two's-complement operand A.
REQ-005 B  input  8  operand B.
REQ-006 Cin  input  1  carry-in to bit 0.
REQ-007 in_valid  input  1  high when A/B/Cin carry a new operation to be captured.
REQ-008 S  output  8  registered sum bits [7:0].
REQ-009 Cout  output  1  registered carry-out of bit 7.
REQ-010 ovf  output  1  registered signed overflow (carry into bit 7 XOR carry out of bit 7).
REQ-011 out_valid  output  1  high for one cycle per accepted operation, aligned with S/Cout/ovf.
REQ-012 The block SHALL have no parameters; width is fixed at 8.

Function
REQ-013 The datapath SHALL be a ripple-carry chain of 8 one-bit full-adder stages.
- Stage i: s[i] = A[i]^B[i]^c[i]; c[i+1] = A[i]&B[i] | c[i]&(A[i]^B[i]); c[0] = Cin.
REQ-014 The combinational result SHALL equal {Cout,S} = A + B + Cin, a 9-bit result; no saturation, wrap modulo 256 in S.
REQ-015 ovf SHALL equal c[7] XOR c[8], computed on the same operands.
REQ-016 On a rising clk edge with in_valid=1, S, Cout and ovf SHALL load the combinational result and out_valid SHALL be 1; latency is exactly 1 cycle.
REQ-017 On a rising clk edge with in_valid=0, S, Cout and ovf SHALL hold their previous values and out_valid SHALL be 0.
REQ-018 Back-to-back in_valid SHALL be accepted every cycle (throughput 1 op/cycle, no backpressure).
REQ-019 Outputs SHALL change only on a clk edge or on reset; input glitches between edges SHALL not reach the outputs.
REQ-020 Boundaries:
- A=B=8'hFF, Cin=1 -> S=8'hFF, Cout=1.
- A=8'hFF, B=0, Cin=1 -> S=0, Cout=1 (wrap).
- Cin=1 with A=B=0 -> S=1, Cout=0.

Reset
REQ-021 While rst=1, S=0, Cout=0, ovf=0, out_valid=0 immediately, with no clk edge needed.
REQ-022 rst asserted mid-operation SHALL discard the operation captured on that edge; no out_valid pulse SHALL follow.
REQ-023 After rst deasserts, the first rising edge with in_valid=1 SHALL produce a valid result on the next cycle as in REQ-016.

Verification
REQ-024 The bench SHALL cover these scenarios:
- A=20, B=31, Cin=1, in_valid=1 -> next cycle S=52, Cout=0, ovf=0, out_valid=1.
- A=8'hFF, B=8'h01, Cin=0 -> S=0, Cout=1, ovf=0.
- A=127, B=1, Cin=0 -> S=128, Cout=0, ovf=1; then A=8'h80, B=8'h80, Cin=0 -> S=0, Cout=1, ovf=1.
- in_valid pulses on 3 consecutive cycles (1+1+0, 2+2+0, 200+100+0) -> S=2, 4, 44 on consecutive cycles; Cout=0, 0, 1; out_valid high 3 cycles.
- in_valid=0 after a result -> S/Cout/ovf hold; out_valid=0.
- rst asserted asynchronously between edges while out_valid=1 -> all outputs 0 immediately; no pulse after release until a new in_valid.
REQ-025 The bench SHALL also run an exhaustive or random sweep of A, B, Cin checked against {Cout,S} = A+B+Cin.
